// File: rtl/mux_select_sequencer.sv
// Drives a word onto a downstream 8:1 mux, walks its select one bit at a time and
// reassembles the returned mux output. Optional self-check comparator via MUXSEQ_CHECK_EN.
module mux_select_sequencer #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic [7:0] mux_a,
  output logic [2:0] mux_s,
  input  logic       mux_c,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout
`ifdef MUXSEQ_CHECK_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [2:0] FIRST_IDX = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST_IDX  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

  state_t     state_reg;
  logic [2:0] idx_reg;
  logic [2:0] idx_next;
  logic [7:0] rx_reg;
  logic [7:0] rx_next;

  assign idx_next = (LSB_FIRST != 0) ? (idx_reg + 3'd1) : (idx_reg - 3'd1);

  // Receive word with the bit currently under the select replaced by the live mux output,
  // so the final bit is already included when the word is published on entry to DONE.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rx
      assign rx_next[gi] = (idx_reg == 3'(gi)) ? mux_c : rx_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mux_a     <= 8'h00;
      mux_s     <= 3'b000;
      idx_reg   <= 3'd0;
      rx_reg    <= 8'h00;
      dout      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MUXSEQ_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mux_a     <= din;
            rx_reg    <= 8'h00;
            idx_reg   <= FIRST_IDX;
            mux_s     <= FIRST_IDX;
            busy      <= 1'b1;
            state_reg <= DRIVE;
          end
        end
        DRIVE: begin
          state_reg <= SAMPLE;
        end
        SAMPLE: begin
          rx_reg <= rx_next;
          if (idx_reg == LAST_IDX) begin
            dout      <= rx_next;
            done      <= 1'b1;
`ifdef MUXSEQ_CHECK_EN
            err       <= (rx_next != mux_a);
`endif
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_next;
            mux_s     <= idx_next;
            state_reg <= DRIVE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
